fault_campaign_ctrl: RTL and testbench
======================================

// Module: fault_campaign_ctrl
// PURPOSE
//   Hardware sequencer for a stuck-at fault campaign on the fault-injectable logic block (top) and its golden twin (logic2).
//   - Walks every test vector x fault node x stuck value.
//   - Drives node-select / stuck-value / primary inputs and waits a settle window.
//   - Compares DUT outputs against golden outputs; streams each detection out over a valid/ready port.
//   - Replaces the delay-driven testbench loop with a synthesizable, cycle-exact campaign engine.
// PARAMETERS
//   N_VEC    16  number of test vectors; vector k is applied as binary k (exhaustive)
//   VEC_W    4   primary input width (vec[3]=in1 .. vec[0]=in4)
//   N_NODE   16  fault nodes, numbered 1..N_NODE
//   SEL_W    5   node-select width; sel=0 means no fault injected
//   OUT_W    2   compared output width ({o1,o2})
//   SETTLE   2   cycles the stimulus is held before compare (>=1)
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      synchronous active-low reset
//   start         in   1      1-cycle pulse; begins campaign when idle
//   busy          out  1      high from cycle after accepted start until done
//   done          out  1      1-cycle pulse when campaign completes
//   vec           out  VEC_W  primary inputs to DUT and golden
//   fault_sel     out  SEL_W  node under fault (0 when idle)
//   fault_val     out  1      stuck value: 0=sa0, 1=sa1
//   dut_o         in   OUT_W  faulted block outputs
//   gold_o        in   OUT_W  golden block outputs
//   det_valid     out  1      detection record valid
//   det_ready     in   1      consumer accepts record
//   det_vec       out  VEC_W  vector that exposed the fault
//   det_node      out  SEL_W  detected node
//   det_sa        out  1      detected stuck value
//   det_cnt       out  10     total detections reported (saturating at 1023)
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; det_cnt=0; drop bitmap cleared.
//   - Iteration order: vec outer (0..N_VEC-1), node middle (1..N_NODE), sa inner (0,1).
//   - FSM states:
//     - IDLE: wait for start. On start go to APPLY with vec=0, node=1, sa=0; busy=1.
//     - APPLY: outputs held stable for SETTLE cycles (settle counter), then go to COMPARE.
//     - COMPARE (1 cycle): if dut_o!=gold_o, latch det_* fields, set det_valid, go to REPORT; else go to NEXT.
//     - REPORT: hold det_* and det_valid stable. On det_valid&&det_ready: det_cnt++ and go to NEXT next cycle.
//     - NEXT (1 cycle): advance indices with wrap (sa 1->0 carries node; node N_NODE->1 carries vec).
//       - Last combination (vec=N_VEC-1, node=N_NODE, sa=1): go to DONE.
//       - Otherwise go to APPLY.
//     - DONE (1 cycle): done=1, busy=0; fault_sel, fault_val and vec return to 0; go to IDLE.
//   - Stimulus outputs change only on entry to APPLY; stable through APPLY, COMPARE and REPORT.
//   - No-detection cost: SETTLE+2 cycles per combination. Defaults: 512*4 = 2048 cycles from start to done.
//   - start while busy is ignored. det_ready is don't-care when det_valid=0.
//   - Stall: det_ready low freezes all indices and stimulus indefinitely.
//   - rst_n low mid-campaign: abandons run, IDLE next cycle, no done pulse.
//   - det_cnt is preserved across runs; it is cleared only by reset.
// CONFIGURATION
//   FAULT_DROP_EN defined:
//     - Keep a 2*N_NODE detected-fault bitmap; set a fault's bit when its record is accepted.
//     - In NEXT, skip already-detected faults (never re-applied); each skipped fault costs 1 cycle in NEXT.
//     - Each fault is reported at most once per run; bitmap is cleared on start.
//   FAULT_DROP_EN undefined: no bitmap; every combination is applied and every mismatch is reported.
// TESTING
//   1. rst_n=0 for 2 cycles mid-run -> busy=0, done=0, fault_sel=0, vec=0, det_valid=0, det_cnt=0.
//   2. start; model dut_o=gold_o always -> done exactly 2048 cycles after start; det_valid never asserted; det_cnt=0.
//   3. Model mismatch only when vec=4'b0000, fault_sel=3, fault_val=1; det_ready=1
//      -> one record {det_vec=0, det_node=3, det_sa=1}; det_cnt=1.
//   4. As test 3 with det_ready=0 for 10 cycles -> det_valid held; fault_sel=3 and vec=0 stable; accepted on ready.
//   5. Model mismatch for node 5 sa0 on all vectors
//      -> FAULT_DROP_EN: one record, det_cnt=1. Undefined: 16 records, det_cnt=16.
//   6. start pulsed while busy -> ignored; order unchanged. After done, new start -> restarts at vec=0, node=1, sa=0.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: walks vector x node x stuck value, compares faulted vs golden
// outputs and streams detections. Define FAULT_DROP_EN to skip faults already detected in a run.
module fault_campaign_ctrl #(
    parameter int unsigned N_VEC  = 16,
    parameter int unsigned VEC_W  = 4,
    parameter int unsigned N_NODE = 16,
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned OUT_W  = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [VEC_W-1:0] vec,
    output logic [SEL_W-1:0] fault_sel,
    output logic             fault_val,
    input  logic [OUT_W-1:0] dut_o,
    input  logic [OUT_W-1:0] gold_o,
    output logic             det_valid,
    input  logic             det_ready,
    output logic [VEC_W-1:0] det_vec,
    output logic [SEL_W-1:0] det_node,
    output logic             det_sa,
    output logic [9:0]       det_cnt
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StCompare,
        StReport,
        StNext,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Campaign indices; they run ahead of the stimulus registers while skipping dropped faults.
    logic [VEC_W-1:0]   ivec_q, ivec_d;
    logic [SEL_W-1:0]   inode_q, inode_d;
    logic               isa_q, isa_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               val_q, val_d;
    logic [VEC_W-1:0]   dvec_q, dvec_d;
    logic [SEL_W-1:0]   dnode_q, dnode_d;
    logic               dsa_q, dsa_d;
    logic [9:0]         dcnt_q, dcnt_d;

    logic               last;
    logic [VEC_W-1:0]   nvec;
    logic [SEL_W-1:0]   nnode;
    logic               nsa;
    logic               skip;

`ifdef FAULT_DROP_EN
    localparam int unsigned BIT_W = $clog2(2 * N_NODE);
    logic [2*N_NODE-1:0] drop_q, drop_d;
    logic [BIT_W-1:0]    cur_bit, nxt_bit;

    assign cur_bit = BIT_W'({inode_q - SEL_W'(1), isa_q});
    assign nxt_bit = BIT_W'({nnode - SEL_W'(1), nsa});
    assign skip    = drop_q[nxt_bit];
`else
    assign skip = 1'b0;
`endif

    assign last = (ivec_q == VEC_W'(N_VEC - 1)) && (inode_q == SEL_W'(N_NODE)) && isa_q;

    always_comb begin
        nvec  = ivec_q;
        nnode = inode_q;
        nsa   = 1'b1;
        if (isa_q) begin
            nsa = 1'b0;
            if (inode_q == SEL_W'(N_NODE)) begin
                nnode = SEL_W'(1);
                nvec  = ivec_q + VEC_W'(1);
            end else begin
                nnode = inode_q + SEL_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ivec_d  = ivec_q;
        inode_d = inode_q;
        isa_d   = isa_q;
        vec_d   = vec_q;
        sel_d   = sel_q;
        val_d   = val_q;
        dvec_d  = dvec_q;
        dnode_d = dnode_q;
        dsa_d   = dsa_q;
        dcnt_d  = dcnt_q;
`ifdef FAULT_DROP_EN
        drop_d  = drop_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StApply;
                    cnt_d   = '0;
                    ivec_d  = '0;
                    inode_d = SEL_W'(1);
                    isa_d   = 1'b0;
                    vec_d   = '0;
                    sel_d   = SEL_W'(1);
                    val_d   = 1'b0;
`ifdef FAULT_DROP_EN
                    drop_d  = '0;
`endif
                end
            end
            StApply: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCompare: begin
                if (dut_o != gold_o) begin
                    dvec_d  = vec_q;
                    dnode_d = sel_q;
                    dsa_d   = val_q;
                    state_d = StReport;
                end else begin
                    state_d = StNext;
                end
            end
            StReport: begin
                if (det_ready) begin
                    if (dcnt_q != 10'h3ff) begin
                        dcnt_d = dcnt_q + 10'd1;
                    end
`ifdef FAULT_DROP_EN
                    drop_d[cur_bit] = 1'b1;
`endif
                    state_d = StNext;
                end
            end
            StNext: begin
                if (last) begin
                    state_d = StDone;
                    vec_d   = '0;
                    sel_d   = '0;
                    val_d   = 1'b0;
                end else begin
                    ivec_d  = nvec;
                    inode_d = nnode;
                    isa_d   = nsa;
                    // A dropped fault only advances the indices; we stay here for one cycle.
                    if (!skip) begin
                        state_d = StApply;
                        cnt_d   = '0;
                        vec_d   = nvec;
                        sel_d   = nnode;
                        val_d   = nsa;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ivec_q  <= '0;
            inode_q <= '0;
            isa_q   <= 1'b0;
            vec_q   <= '0;
            sel_q   <= '0;
            val_q   <= 1'b0;
            dvec_q  <= '0;
            dnode_q <= '0;
            dsa_q   <= 1'b0;
            dcnt_q  <= '0;
`ifdef FAULT_DROP_EN
            drop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ivec_q  <= ivec_d;
            inode_q <= inode_d;
            isa_q   <= isa_d;
            vec_q   <= vec_d;
            sel_q   <= sel_d;
            val_q   <= val_d;
            dvec_q  <= dvec_d;
            dnode_q <= dnode_d;
            dsa_q   <= dsa_d;
            dcnt_q  <= dcnt_d;
`ifdef FAULT_DROP_EN
            drop_q  <= drop_d;
`endif
        end
    end

    assign busy      = (state_q == StApply) || (state_q == StCompare) ||
                       (state_q == StReport) || (state_q == StNext);
    assign done      = (state_q == StDone);
    assign det_valid = (state_q == StReport);
    assign vec       = vec_q;
    assign fault_sel = sel_q;
    assign fault_val = val_q;
    assign det_vec   = dvec_q;
    assign det_node  = dnode_q;
    assign det_sa    = dsa_q;
    assign det_cnt   = dcnt_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl: table of campaign scenarios plus reset/abort sequences.
module tb_fault_campaign_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done;
    logic [3:0] vec;
    logic [4:0] fault_sel;
    logic       fault_val;
    logic [1:0] dut_o, gold_o;
    logic       det_valid;
    logic       det_ready;
    logic [3:0] det_vec;
    logic [4:0] det_node;
    logic       det_sa;
    logic [9:0] det_cnt;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int stall_cfg = 0;
    int exp_cnt  = 0;
    int rq_v[$];
    int rq_n[$];
    int rq_s[$];

    typedef struct {
        int mode;
        int stall;
        int recs;
        int lat;
        int rv;
        int rn;
        int rs;
    } case_t;
    case_t tbl[5];

    always #5 clk = ~clk;

    fault_campaign_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .vec       (vec),
        .fault_sel (fault_sel),
        .fault_val (fault_val),
        .dut_o     (dut_o),
        .gold_o    (gold_o),
        .det_valid (det_valid),
        .det_ready (det_ready),
        .det_vec   (det_vec),
        .det_node  (det_node),
        .det_sa    (det_sa),
        .det_cnt   (det_cnt)
    );

    // Golden block model plus a scenario-selected injected mismatch.
    logic hit;
    always_comb begin
        gold_o = {vec[3] ^ vec[0], vec[1] & vec[2]};
        hit    = ((mode == 1) && (vec == 4'd0) && (fault_sel == 5'd3) && fault_val) ||
                 ((mode == 2) && (fault_sel == 5'd5) && !fault_val);
        dut_o  = gold_o ^ {1'b0, hit};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit         in_rep = 0;
        int         stall_left = 0;
        logic [3:0] hv;
        logic [4:0] hn;
        logic       hs;
        det_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (det_valid) begin
                if (!in_rep) begin
                    in_rep     = 1;
                    stall_left = stall_cfg;
                    hv = det_vec;
                    hn = det_node;
                    hs = det_sa;
                end else begin
                    chk("report_hold", int'({det_vec, det_node, det_sa, vec, fault_sel}),
                        int'({hv, hn, hs, hv, hn}));
                end
                if (stall_left == 0) begin
                    det_ready = 1'b1;
                    rq_v.push_back(int'(det_vec));
                    rq_n.push_back(int'(det_node));
                    rq_s.push_back(int'(det_sa));
                    in_rep = 0;
                end else begin
                    det_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                in_rep    = 0;
                det_ready = (stall_cfg == 0);
            end
        end
    endtask

    task automatic run_case(input int i);
        int cyc;
        mode      = tbl[i].mode;
        stall_cfg = tbl[i].stall;
        rq_v.delete();
        rq_n.delete();
        rq_s.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("start_stim", int'({busy, vec, fault_sel, fault_val}),
            int'({1'b1, 4'd0, 5'd1, 1'b0}));
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 100);  // stray start while busy
        end
        start = 1'b0;
        chk("done_seen", int'(done), 1);
        chk("latency", cyc - 1, tbl[i].lat);
        chk("done_idle_out", int'({busy, vec, fault_sel, fault_val}), 0);
        chk("rec_count", rq_v.size(), tbl[i].recs);
        exp_cnt += tbl[i].recs;
        chk("det_cnt", int'(det_cnt), exp_cnt);
        if (rq_v.size() > 0) begin
            chk("rec0_fields", rq_v[0] * 64 + rq_n[0] * 2 + rq_s[0],
                tbl[i].rv * 64 + tbl[i].rn * 2 + tbl[i].rs);
        end
        if (tbl[i].mode == 2) begin
            foreach (rq_v[k]) begin
                chk("mode2_rec", rq_v[k] * 64 + rq_n[k] * 2 + rq_s[k], k * 64 + 5 * 2 + 0);
            end
        end
        @(negedge clk);
        chk("done_pulse", int'({done, busy}), 0);
    endtask

    initial begin
        int seen;
        tbl[0] = '{mode: 0, stall: 0,  recs: 0, lat: 2048, rv: 0, rn: 0, rs: 0};
        tbl[1] = '{mode: 1, stall: 0,  recs: 1, lat: 2049, rv: 0, rn: 3, rs: 1};
        tbl[2] = '{mode: 1, stall: 10, recs: 1, lat: 2059, rv: 0, rn: 3, rs: 1};
`ifdef FAULT_DROP_EN
        tbl[3] = '{mode: 2, stall: 0,  recs: 1,  lat: 2004, rv: 0, rn: 5, rs: 0};
        tbl[4] = '{mode: 2, stall: 3,  recs: 1,  lat: 2007, rv: 0, rn: 5, rs: 0};
`else
        tbl[3] = '{mode: 2, stall: 0,  recs: 16, lat: 2064, rv: 0, rn: 5, rs: 0};
        tbl[4] = '{mode: 2, stall: 3,  recs: 16, lat: 2112, rv: 0, rn: 5, rs: 0};
`endif
        fork
            monitor();
        join_none

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_det_valid", int'(det_valid), 0);
        chk("rst_stim", int'({vec, fault_sel, fault_val}), 0);
        chk("rst_det_fields", int'({det_vec, det_node, det_sa}), 0);
        chk("rst_det_cnt", int'(det_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_case(i);
        end

        // Abort a run with one accepted record, then verify reset clears everything.
        mode      = 1;
        stall_cfg = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_pre_cnt", int'(det_cnt), (exp_cnt + 1) % 1024);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_stim", int'({vec, fault_sel, fault_val}), 0);
        chk("abort_det_valid", int'(det_valid), 0);
        chk("abort_det_cnt", int'(det_cnt), 0);
        exp_cnt = 0;
        rst_n   = 1'b1;
        seen    = 0;
        repeat (2200) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);

        run_case(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
